// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completion packets from the functional units in
// per-source FIFOs and broadcasts at most one per cycle on the common data
// bus, choosing among non-empty FIFOs round-robin.

package cdb_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [5:0]  Tag;
    logic [31:0] Value;
    logic [31:0] alu_result;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic [31:0] inst;
    logic        take_branch;
    logic        halt;
    logic        illegal;
  } CDB_PACKET;

endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               squash_signal,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  CDB_PACKET [NUM_FU-1:0]             fu_packet,
  output logic [NUM_FU-1:0]                  fu_ready,
  output CDB_PACKET                          cdb_packet_out,
  output logic [$clog2(NUM_FU)-1:0]          cdb_src,
  output logic [$clog2(NUM_FU*DEPTH+1)-1:0]  pending
);

  localparam int unsigned SW = $clog2(NUM_FU);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(NUM_FU*DEPTH+1);

  CDB_PACKET         mem     [NUM_FU][DEPTH];
  logic [PW-1:0]     wr_ptr  [NUM_FU];
  logic [PW-1:0]     rd_ptr  [NUM_FU];
  logic [PW-1:0]     cnt     [NUM_FU];
  logic [PW-1:0]     cnt_nxt [NUM_FU];
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     grant_idx;
  logic [SW-1:0]     scan_idx;
  logic              grant_vld;
  logic [CW-1:0]     pend_nxt;
  CDB_PACKET         head_pkt;

  // Per-FIFO occupancy, readiness (registered state only) and accepted pushes
  always_comb begin
    empty    = '0;
    fu_ready = '0;
    push     = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      cnt[i]      = wr_ptr[i] - rd_ptr[i];
      empty[i]    = (wr_ptr[i] == rd_ptr[i]);
      fu_ready[i] = reset_n && (cnt[i] < PW'(DEPTH));
      push[i]     = fu_valid[i] && fu_ready[i] && !squash_signal;
    end
  end

  // Round-robin search from rr_ptr upward, wrapping; first non-empty FIFO wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    pop       = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan_idx = SW'((32'(rr_ptr) + k) % NUM_FU);
      if (!grant_vld && !empty[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_vld) pop[grant_idx] = 1'b1;
    head_pkt       = mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
    head_pkt.valid = 1'b1;
  end

  // Next-state occupancy summed into the pending count; a squash empties all
  always_comb begin
    pend_nxt = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      cnt_nxt[i] = cnt[i] + PW'(push[i]) - PW'(pop[i]);
      pend_nxt   = pend_nxt + CW'(cnt_nxt[i]);
    end
    if (squash_signal) pend_nxt = '0;
  end

  // FIFO pointers: reset and squash empty every buffer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else if (squash_signal) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // FIFO storage: write accepted packets at the tail
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= fu_packet[i];
    end
  end

  // CDB output register, source index, round-robin pointer and pending count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_packet_out <= '0;
      cdb_src        <= '0;
      rr_ptr         <= '0;
      pending        <= '0;
    end else if (squash_signal) begin
      cdb_packet_out.valid <= 1'b0;
      rr_ptr               <= '0;
      pending              <= '0;
    end else begin
      pending <= pend_nxt;
      if (grant_vld) begin
        cdb_packet_out <= head_pkt;
        cdb_src        <= grant_idx;
        rr_ptr         <= (grant_idx == SW'(NUM_FU-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        cdb_packet_out.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a scoreboard queue of hand-computed
// CDB outputs; a monitor pops and compares whenever the CDB carries a packet.

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NUM_FU = 4;
  localparam int unsigned DEPTH  = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             squash_signal;
  logic [3:0]       fu_valid;
  CDB_PACKET [3:0]  fu_packet;
  logic [3:0]       fu_ready;
  CDB_PACKET        cdb_packet_out;
  logic [1:0]       cdb_src;
  logic [3:0]       pending;

  typedef struct {
    logic [5:0] tag;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cdb_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .squash_signal  (squash_signal),
    .fu_valid       (fu_valid),
    .fu_packet      (fu_packet),
    .fu_ready       (fu_ready),
    .cdb_packet_out (cdb_packet_out),
    .cdb_src        (cdb_src),
    .pending        (pending)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] value_of(input logic [5:0] tag);
    return 32'hC0DE_0000 | {26'd0, tag};
  endfunction

  function automatic CDB_PACKET mk_pkt(input logic [5:0] tag);
    CDB_PACKET p;
    p       = '0;
    p.valid = 1'b1;
    p.Tag   = tag;
    p.Value = value_of(tag);
    p.PC    = 32'h0000_1000 + {24'd0, tag, 2'b00};
    p.NPC   = p.PC + 32'd4;
    p.inst  = 32'h0000_0013;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input int tag, input int src);
    exp_t e;
    e.tag = 6'(tag);
    e.src = 2'(src);
    exp_q.push_back(e);
  endtask

  task automatic pulse_squash();
    squash_signal = 1'b1;
    @(negedge clock);
    squash_signal = 1'b0;
  endtask

  // Monitor: every live CDB packet must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (cdb_packet_out.valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL cdb_unexpected: got tag %0d src %0d, expected no packet",
                   cdb_packet_out.Tag, cdb_src);
        end else begin
          e = exp_q.pop_front();
          if (cdb_packet_out.Tag !== e.tag || cdb_src !== e.src ||
              cdb_packet_out.Value !== value_of(e.tag)) begin
            n_bad++;
            $display("FAIL cdb_packet: got tag %0d src %0d value 0x%0h, expected tag %0d src %0d value 0x%0h",
                     cdb_packet_out.Tag, cdb_src, cdb_packet_out.Value,
                     e.tag, e.src, value_of(e.tag));
          end
        end
      end
    end
  end

  initial begin
    int         sent [4];
    int         total;
    int         cyc;
    logic [3:0] rdy;
    logic [3:0] drv;

    reset_n       = 1'b0;
    squash_signal = 1'b0;
    fu_valid      = '0;
    fu_packet     = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ready",   64'(fu_ready), 64'h0);
    check("rst_valid",   64'(cdb_packet_out.valid), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_src",     64'(cdb_src), 64'h0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst", 64'(fu_ready), 64'hF);

    // Single packet on source 2: visible after E+1 only
    fu_valid     = 4'b0100;
    fu_packet[2] = mk_pkt(6'd5);
    expect_out(5, 2);
    @(negedge clock);
    fu_valid = '0;
    check("single_pending", 64'(pending), 64'd1);
    @(negedge clock);
    check("single_valid_e1", 64'(cdb_packet_out.valid), 64'd1);
    @(negedge clock);
    check("single_valid_e2", 64'(cdb_packet_out.valid), 64'd0);
    check("single_pending_e2", 64'(pending), 64'd0);

    // Round robin from rr_ptr=0
    pulse_squash();
    fu_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      fu_packet[s] = mk_pkt(6'(10 + s));
      expect_out(10 + s, s);
    end
    @(negedge clock);
    fu_valid = '0;
    check("rr_pending_full", 64'(pending), 64'd4);
    repeat (4) @(negedge clock);
    check("rr_pending_empty", 64'(pending), 64'd0);

    // Backpressure: all sources saturated, four packets each
    pulse_squash();
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < 4; s++)
        expect_out(s*16 + r, s);
    for (int s = 0; s < 4; s++) sent[s] = 0;
    total = 0;
    cyc   = 0;
    while (total < 16 && cyc < 40) begin
      for (int s = 0; s < 4; s++) begin
        fu_valid[s] = (sent[s] < 4);
        if (sent[s] < 4) fu_packet[s] = mk_pkt(6'(s*16 + sent[s]));
      end
      if (cyc == 2) check("bp_ready_full", 64'(fu_ready), 64'b0001);
      rdy = fu_ready;
      drv = fu_valid;
      @(negedge clock);
      cyc++;
      for (int s = 0; s < 4; s++)
        if (drv[s] && rdy[s]) begin
          sent[s]++;
          total++;
        end
    end
    fu_valid = '0;
    check("bp_all_sent", 64'(total), 64'd16);
    repeat (20) @(negedge clock);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_pending", 64'(pending), 64'd0);

    // Single source streaming: push and pop every cycle
    for (int k = 0; k < 8; k++) begin
      fu_valid     = 4'b0001;
      fu_packet[0] = mk_pkt(6'(k));
      expect_out(k, 0);
      check("stream_ready", 64'(fu_ready[0]), 64'd1);
      check("stream_pending_le1", 64'(pending <= 4'd1), 64'd1);
      if (k >= 2) check("stream_cdb_valid", 64'(cdb_packet_out.valid), 64'd1);
      @(negedge clock);
    end
    fu_valid = '0;
    repeat (3) @(negedge clock);

    // Squash with six packets buffered while source 3 presents tag 9
    pulse_squash();
    fu_valid = 4'hF;
    for (int s = 0; s < 4; s++) fu_packet[s] = mk_pkt(6'(30 + s));
    expect_out(30, 0);
    @(negedge clock);
    fu_valid = 4'b0111;
    for (int s = 0; s < 3; s++) fu_packet[s] = mk_pkt(6'(34 + s));
    @(negedge clock);
    check("sq_pending_before", 64'(pending), 64'd6);
    fu_valid      = 4'b1000;
    fu_packet[3]  = mk_pkt(6'd9);
    squash_signal = 1'b1;
    @(negedge clock);
    squash_signal = 1'b0;
    fu_valid      = '0;
    check("sq_pending_after", 64'(pending), 64'd0);
    check("sq_valid_after", 64'(cdb_packet_out.valid), 64'd0);
    // rr_ptr back at 0: a full round must start at source 0
    fu_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      fu_packet[s] = mk_pkt(6'(40 + s));
      expect_out(40 + s, s);
    end
    @(negedge clock);
    fu_valid = '0;
    repeat (6) @(negedge clock);

    // Asynchronous reset between edges with three packets buffered
    fu_valid = 4'hF;
    for (int s = 0; s < 4; s++) fu_packet[s] = mk_pkt(6'(50 + s));
    expect_out(50, 0);
    @(negedge clock);
    fu_valid = '0;
    @(negedge clock);
    check("ar_pending_before", 64'(pending), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid",   64'(cdb_packet_out.valid), 64'd0);
    check("ar_tag",     64'(cdb_packet_out.Tag), 64'd0);
    check("ar_src",     64'(cdb_src), 64'd0);
    check("ar_pending", 64'(pending), 64'd0);
    check("ar_ready",   64'(fu_ready), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    #1;
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("final_pending", 64'(pending), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
